// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit:
// operation encodings, FSM state encoding, default datapath width and
// a small decode helper.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // True for the two operations that treat their operands as two's complement.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One bit of a restoring division: shift the next dividend bit into the
// partial remainder, try to subtract the divisor, keep the difference only
// when it does not borrow, and shift the resulting quotient bit in.
// quot_i carries the not-yet-consumed dividend bits in its upper part and
// the quotient bits produced so far in its lower part.
module restoring_div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // Trial subtraction; a clear top bit of the difference means the divisor fits.
  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    fits    = ~diff[WIDTH];
    rem_o   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_o  = {quot_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage HI/LO multiply/divide unit. MULT/MULTU/DIV/DIVU run iteratively
// (one bit per cycle, WIDTH cycles) on operand magnitudes, and the signs are
// restored in a final FIX cycle. MTHI/MTLO write HI/LO directly when idle.
// busy tells the hazard unit to hold ID/EX and any MFHI/MFLO.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU finish on the start
// edge through a single wide multiplier; division stays iterative.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       md_op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rs_raw_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic               done_q;

  logic               op_is_mul;
  logic               op_is_div;
  logic               launch_iter;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quot_next;
  logic [2*WIDTH-1:0] mul_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Decode the incoming operation and form operand magnitudes for signed ops.
  always_comb begin
    op_is_mul = (md_op_i == MD_MULT) || (md_op_i == MD_MULTU);
    op_is_div = (md_op_i == MD_DIV)  || (md_op_i == MD_DIVU);
    rs_neg    = md_is_signed(md_op_i) && rs_val_i[WIDTH-1];
    rt_neg    = md_is_signed(md_op_i) && rt_val_i[WIDTH-1];
    rs_mag    = rs_neg ? (~rs_val_i + 1'b1) : rs_val_i;
    rt_mag    = rt_neg ? (~rt_val_i + 1'b1) : rt_val_i;
`ifdef MULDIV_FAST_MUL_EN
    launch_iter = start_i && (state_q == S_IDLE) && op_is_div;
`else
    launch_iter = start_i && (state_q == S_IDLE) && (op_is_mul || op_is_div);
`endif
  end

`ifdef MULDIV_FAST_MUL_EN
  logic               fast_mul_go;
  logic [2*WIDTH-1:0] fast_a;
  logic [2*WIDTH-1:0] fast_b;
  logic [2*WIDTH-1:0] fast_prod;

  // Extending both operands to 2*WIDTH makes the low 2*WIDTH product bits exact for either signedness.
  always_comb begin
    fast_mul_go = start_i && (state_q == S_IDLE) && op_is_mul;
    fast_a      = md_is_signed(md_op_i) ? {{WIDTH{rs_val_i[WIDTH-1]}}, rs_val_i}
                                        : {{WIDTH{1'b0}}, rs_val_i};
    fast_b      = md_is_signed(md_op_i) ? {{WIDTH{rt_val_i[WIDTH-1]}}, rt_val_i}
                                        : {{WIDTH{1'b0}}, rt_val_i};
    fast_prod   = fast_a * fast_b;
  end
`endif

  // Shift-add multiply step: add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  restoring_div_step #(
    .WIDTH     (WIDTH)
  ) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .quot_i    (acc_q[WIDTH-1:0]),
    .divisor_i (b_q),
    .rem_o     (div_rem_next),
    .quot_o    (div_quot_next)
  );

  assign div_next = {div_rem_next, div_quot_next};

  // Restore result signs; a zero divisor returns the raw dividend in HI and all ones in LO.
  always_comb begin
    mul_fixed = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    if (!is_div_q) begin
      fix_hi = mul_fixed[2*WIDTH-1:WIDTH];
      fix_lo = mul_fixed[WIDTH-1:0];
    end else if (div0_q) begin
      fix_hi = rs_raw_q;
      fix_lo = {WIDTH{1'b1}};
    end else begin
      fix_hi = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      fix_lo = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
  end

  // Control FSM together with the HI/LO and iteration registers; starts are only accepted in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      rs_raw_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch_iter) begin
            acc_q     <= {{WIDTH{1'b0}}, (op_is_div ? rs_mag : rt_mag)};
            b_q       <= op_is_div ? rt_mag : rs_mag;
            rs_raw_q  <= rs_val_i;
            is_div_q  <= op_is_div;
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
            div0_q    <= op_is_div && (rt_val_i == '0);
            cnt_q     <= '0;
            state_q   <= S_CALC;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (fast_mul_go) begin
            hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
            lo_q   <= fast_prod[WIDTH-1:0];
            done_q <= 1'b1;
          end
`endif
          else if (start_i && (md_op_i == MD_MTHI)) begin
            hi_q <= rs_val_i;
          end else if (start_i && (md_op_i == MD_MTLO)) begin
            lo_q <= rs_val_i;
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
